controle_multiciclo: RTL and testbench

//  Moore/Mealy FSM sequencing the multicycle MIPS-subset datapath: drives PC/IR write, memory

---
 rtl/controle_multiciclo_if.sv | 38 +++
 rtl/controle_multiciclo.sv | 173 +++++++++++++++++
 tb/tb_controle_multiciclo.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle controller and the MIPS-subset datapath.
// master: the controller (reads IR fields and memory ready, drives every select/enable).
// slave : the datapath side.
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_pronta;
  logic       pc_escreve;
  logic       pc_escreve_cond;
  logic       ir_escreve;
  logic       mem_le;
  logic       mem_escreve;
  logic       i_ou_d;
  logic       reg_dst;
  logic       mem_para_reg;
  logic       reg_escreve;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_fonte;
  logic       instrucao_concluida;
  logic       erro;
  logic [3:0] estado;

  modport master (
    input  opcode, funct, mem_pronta,
    output pc_escreve, pc_escreve_cond, ir_escreve, mem_le, mem_escreve, i_ou_d,
           reg_dst, mem_para_reg, reg_escreve, alu_src_a, alu_src_b, alu_op,
           pc_fonte, instrucao_concluida, erro, estado
  );

  modport slave (
    output opcode, funct, mem_pronta,
    input  pc_escreve, pc_escreve_cond, ir_escreve, mem_le, mem_escreve, i_ou_d,
           reg_dst, mem_para_reg, reg_escreve, alu_src_a, alu_src_b, alu_op,
           pc_fonte, instrucao_concluida, erro, estado
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset controller: sequences fetch/decode/execute/memory/write-back
// over a variable-latency memory, with a watchdog that parks the FSM in ERRO when a
// memory access stalls for TIMEOUT_MEM cycles (0 disables the watchdog).
module controle_multiciclo #(
  parameter int unsigned TIMEOUT_MEM = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  controle_multiciclo_if.master ctrl
);

  typedef enum logic [3:0] {
    BUSCA       = 4'd0,
    DECODIFICA  = 4'd1,
    CALC_END    = 4'd2,
    LE_MEM      = 4'd3,
    WB_MEM      = 4'd4,
    ESCREVE_MEM = 4'd5,
    EXECUTA_R   = 4'd6,
    WB_R        = 4'd7,
    DESVIO      = 4'd8,
    SALTO       = 4'd9,
    EXECUTA_I   = 4'd10,
    WB_I        = 4'd11,
    ERRO        = 4'd15
  } estado_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam int unsigned    WD_W   = (TIMEOUT_MEM > 1) ? $clog2(TIMEOUT_MEM) : 1;
  localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT_MEM > 0) ? WD_W'(TIMEOUT_MEM - 1) : '0;

  estado_t         estado;
  estado_t         proximo;
  logic [WD_W-1:0] watchdog;
  logic            espera;
  logic            estouro;

  // A cycle counts toward the watchdog only while a memory request is pending.
  assign espera  = (estado == BUSCA || estado == LE_MEM || estado == ESCREVE_MEM) && !ctrl.mem_pronta;
  assign estouro = (TIMEOUT_MEM != 0) && (watchdog == WD_MAX);

  // Next-state selection; a ready on the last watchdog cycle still takes the normal path.
  always_comb begin
    proximo = estado;
    case (estado)
      BUSCA:       if (ctrl.mem_pronta) proximo = DECODIFICA;
      DECODIFICA: begin
        case (ctrl.opcode)
          OP_R:                    proximo = EXECUTA_R;
          OP_LW, OP_SW:            proximo = CALC_END;
          OP_BEQ:                  proximo = DESVIO;
          OP_J:                    proximo = SALTO;
          OP_ADDI, OP_ANDI, OP_ORI: proximo = EXECUTA_I;
          default:                 proximo = ERRO;
        endcase
      end
      CALC_END:    proximo = (ctrl.opcode == OP_SW) ? ESCREVE_MEM : LE_MEM;
      LE_MEM:      if (ctrl.mem_pronta) proximo = WB_MEM;
      WB_MEM:      proximo = BUSCA;
      ESCREVE_MEM: if (ctrl.mem_pronta) proximo = BUSCA;
      EXECUTA_R:   proximo = WB_R;
      WB_R:        proximo = BUSCA;
      DESVIO:      proximo = BUSCA;
      SALTO:       proximo = BUSCA;
      EXECUTA_I:   proximo = WB_I;
      WB_I:        proximo = BUSCA;
      ERRO:        proximo = ERRO;
      default:     proximo = ERRO;
    endcase
    if (espera && estouro) proximo = ERRO;
  end

  // State register and watchdog; the count restarts whenever the state changes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado   <= BUSCA;
      watchdog <= '0;
    end else begin
      estado <= proximo;
      if (proximo != estado) watchdog <= '0;
      else if (espera)       watchdog <= watchdog + 1'b1;
    end
  end

  // Control decode from the current state; fetch and store completion react to mem_pronta.
  always_comb begin
    ctrl.pc_escreve          = 1'b0;
    ctrl.pc_escreve_cond     = 1'b0;
    ctrl.ir_escreve          = 1'b0;
    ctrl.mem_le              = 1'b0;
    ctrl.mem_escreve         = 1'b0;
    ctrl.i_ou_d              = 1'b0;
    ctrl.reg_dst             = 1'b0;
    ctrl.mem_para_reg        = 1'b0;
    ctrl.reg_escreve         = 1'b0;
    ctrl.alu_src_a           = 1'b0;
    ctrl.alu_src_b           = 2'b00;
    ctrl.alu_op              = 2'b00;
    ctrl.pc_fonte            = 2'b00;
    ctrl.instrucao_concluida = 1'b0;
    ctrl.erro                = 1'b0;
    ctrl.estado              = estado;
    case (estado)
      BUSCA: begin
        ctrl.mem_le     = 1'b1;
        ctrl.alu_src_b  = 2'b01;
        ctrl.ir_escreve = ctrl.mem_pronta;
        ctrl.pc_escreve = ctrl.mem_pronta;
      end
      DECODIFICA: ctrl.alu_src_b = 2'b11;
      CALC_END: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      LE_MEM: begin
        ctrl.mem_le = 1'b1;
        ctrl.i_ou_d = 1'b1;
      end
      WB_MEM: begin
        ctrl.reg_escreve         = 1'b1;
        ctrl.mem_para_reg        = 1'b1;
        ctrl.reg_dst             = 1'b1;
        ctrl.instrucao_concluida = 1'b1;
      end
      ESCREVE_MEM: begin
        ctrl.mem_escreve         = 1'b1;
        ctrl.i_ou_d              = 1'b1;
        ctrl.instrucao_concluida = ctrl.mem_pronta;
      end
      EXECUTA_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      WB_R: begin
        ctrl.reg_escreve         = 1'b1;
        ctrl.instrucao_concluida = 1'b1;
      end
      DESVIO: begin
        ctrl.alu_src_a           = 1'b1;
        ctrl.alu_op              = 2'b01;
        ctrl.pc_escreve_cond     = 1'b1;
        ctrl.pc_fonte            = 2'b01;
        ctrl.instrucao_concluida = 1'b1;
      end
      SALTO: begin
        ctrl.pc_escreve          = 1'b1;
        ctrl.pc_fonte            = 2'b10;
        ctrl.instrucao_concluida = 1'b1;
      end
      EXECUTA_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = (ctrl.opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      WB_I: begin
        ctrl.reg_escreve         = 1'b1;
        ctrl.reg_dst             = 1'b1;
        ctrl.instrucao_concluida = 1'b1;
      end
      ERRO:    ctrl.erro = 1'b1;
      default: ctrl.erro = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: each instruction is expanded into its expected
// per-cycle trace (state, controls, memory ready to drive), then replayed against the DUT.
module tb_controle_multiciclo;

  localparam int unsigned TMO = 16;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic [3:0] estado;
    logic       pc_escreve;
    logic       pc_escreve_cond;
    logic       ir_escreve;
    logic       mem_le;
    logic       mem_escreve;
    logic       i_ou_d;
    logic       reg_dst;
    logic       mem_para_reg;
    logic       reg_escreve;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_fonte;
    logic       concl;
    logic       erro;
  } ctl_t;

  typedef struct packed {
    logic       rst_n;
    logic       mp;
    logic [5:0] op;
    ctl_t       exp;
  } item_t;

  item_t q[$];
  logic  clock   = 1'b0;
  logic  reset_n = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  controle_multiciclo_if bus ();

  controle_multiciclo #(.TIMEOUT_MEM(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clock = ~clock;

  function automatic ctl_t st(input logic [3:0] e);
    ctl_t c = '0;
    c.estado = e;
    return c;
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic void push(input logic rst_n, input logic mp, input logic [5:0] op, input ctl_t c);
    item_t it;
    it.rst_n = rst_n;
    it.mp    = mp;
    it.op    = op;
    it.exp   = c;
    q.push_back(it);
  endfunction

  function automatic ctl_t busca_idle();
    ctl_t c = st(4'd0);
    c.mem_le    = 1'b1;
    c.alu_src_b = 2'b01;
    return c;
  endfunction

  function automatic ctl_t erro_ctl();
    ctl_t c = st(4'd15);
    c.erro = 1'b1;
    return c;
  endfunction

  // ERRO holds for n cycles regardless of inputs, then reset_n=0 is applied in one more ERRO cycle.
  function automatic void erro_then_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(1'b1, rbit(), junk(), erro_ctl());
    push(1'b0, rbit(), junk(), erro_ctl());
  endfunction

  // A memory access with w stalled cycles; returns 1 if the watchdog expires first.
  function automatic bit mem_access(input ctl_t busy, input ctl_t pronto, input int unsigned w,
                                    input logic [5:0] op, input bit fetch);
    int unsigned n = (w >= TMO) ? TMO : w;
    for (int unsigned i = 0; i < n; i++) push(1'b1, 1'b0, fetch ? junk() : op, busy);
    if (w >= TMO) return 1'b1;
    push(1'b1, 1'b1, fetch ? junk() : op, pronto);
    return 1'b0;
  endfunction

  // Expected trace for one instruction: wf fetch stalls, wm data stalls, hold = ERRO cycles before reset.
  function automatic void gen_instr(input logic [5:0] op, input int unsigned wf,
                                    input int unsigned wm, input int unsigned hold);
    ctl_t b;
    ctl_t r;
    b = busca_idle();
    r = b;
    r.ir_escreve = 1'b1;
    r.pc_escreve = 1'b1;
    if (mem_access(b, r, wf, op, 1'b1)) begin
      erro_then_reset(hold);
      return;
    end
    b = st(4'd1);
    b.alu_src_b = 2'b11;
    push(1'b1, rbit(), op, b);
    case (op)
      OP_R: begin
        b = st(4'd6); b.alu_src_a = 1'b1; b.alu_op = 2'b10;
        push(1'b1, rbit(), op, b);
        b = st(4'd7); b.reg_escreve = 1'b1; b.concl = 1'b1;
        push(1'b1, rbit(), op, b);
      end
      OP_LW, OP_SW: begin
        b = st(4'd2); b.alu_src_a = 1'b1; b.alu_src_b = 2'b10;
        push(1'b1, rbit(), op, b);
        if (op == OP_LW) begin
          b = st(4'd3); b.mem_le = 1'b1; b.i_ou_d = 1'b1;
          if (mem_access(b, b, wm, op, 1'b0)) begin
            erro_then_reset(hold);
            return;
          end
          b = st(4'd4); b.reg_escreve = 1'b1; b.mem_para_reg = 1'b1; b.reg_dst = 1'b1; b.concl = 1'b1;
          push(1'b1, rbit(), op, b);
        end else begin
          b = st(4'd5); b.mem_escreve = 1'b1; b.i_ou_d = 1'b1;
          r = b; r.concl = 1'b1;
          if (mem_access(b, r, wm, op, 1'b0)) begin
            erro_then_reset(hold);
            return;
          end
        end
      end
      OP_BEQ: begin
        b = st(4'd8); b.alu_src_a = 1'b1; b.alu_op = 2'b01; b.pc_escreve_cond = 1'b1;
        b.pc_fonte = 2'b01; b.concl = 1'b1;
        push(1'b1, rbit(), op, b);
      end
      OP_J: begin
        b = st(4'd9); b.pc_escreve = 1'b1; b.pc_fonte = 2'b10; b.concl = 1'b1;
        push(1'b1, rbit(), op, b);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        b = st(4'd10); b.alu_src_a = 1'b1; b.alu_src_b = 2'b10;
        b.alu_op = (op == OP_ADDI) ? 2'b00 : 2'b11;
        push(1'b1, rbit(), op, b);
        b = st(4'd11); b.reg_escreve = 1'b1; b.reg_dst = 1'b1; b.concl = 1'b1;
        push(1'b1, rbit(), op, b);
      end
      default: erro_then_reset(hold);
    endcase
  endfunction

  // lw aborted by reset_n=0 after k stalled cycles in the data read.
  function automatic void gen_lw_abort(input int unsigned k);
    ctl_t b;
    b = busca_idle(); b.ir_escreve = 1'b1; b.pc_escreve = 1'b1;
    push(1'b1, 1'b1, junk(), b);
    b = st(4'd1); b.alu_src_b = 2'b11;
    push(1'b1, rbit(), OP_LW, b);
    b = st(4'd2); b.alu_src_a = 1'b1; b.alu_src_b = 2'b10;
    push(1'b1, rbit(), OP_LW, b);
    b = st(4'd3); b.mem_le = 1'b1; b.i_ou_d = 1'b1;
    for (int unsigned i = 0; i < k; i++) push(1'b1, 1'b0, OP_LW, b);
    push(1'b0, 1'b0, OP_LW, b);
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.estado          = bus.estado;
    c.pc_escreve      = bus.pc_escreve;
    c.pc_escreve_cond = bus.pc_escreve_cond;
    c.ir_escreve      = bus.ir_escreve;
    c.mem_le          = bus.mem_le;
    c.mem_escreve     = bus.mem_escreve;
    c.i_ou_d          = bus.i_ou_d;
    c.reg_dst         = bus.reg_dst;
    c.mem_para_reg    = bus.mem_para_reg;
    c.reg_escreve     = bus.reg_escreve;
    c.alu_src_a       = bus.alu_src_a;
    c.alu_src_b       = bus.alu_src_b;
    c.alu_op          = bus.alu_op;
    c.pc_fonte        = bus.pc_fonte;
    c.concl           = bus.instrucao_concluida;
    c.erro            = bus.erro;
    return c;
  endfunction

  initial begin
    logic [5:0]  legal [8];
    logic [5:0]  op;
    int unsigned wf;
    int unsigned wm;
    item_t       it;
    ctl_t        obs;
    int unsigned idx;
    logic        prev_rst_n;

    legal = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
    bus.mem_pronta = 1'b0;
    bus.opcode     = '0;
    bus.funct      = '0;
    reset_n        = 1'b0;

    // reset held for two cycles: BUSCA, fetch request only
    push(1'b0, 1'b0, junk(), busca_idle());
    push(1'b0, 1'b0, junk(), busca_idle());

    // directed instructions, memory ready immediately unless noted
    gen_instr(OP_R, 0, 0, 1);
    gen_instr(OP_LW, 0, 3, 1);
    gen_instr(OP_SW, 0, 0, 1);
    gen_instr(OP_BEQ, 0, 0, 1);
    gen_instr(OP_J, 0, 0, 1);
    gen_instr(OP_ADDI, 1, 0, 1);
    gen_instr(OP_ANDI, 0, 0, 1);
    gen_instr(OP_ORI, 2, 0, 1);
    gen_instr(6'h3F, 0, 0, 20);
    gen_instr(OP_R, 16, 0, 3);
    gen_instr(OP_SW, 15, 15, 1);
    gen_instr(OP_LW, 15, 15, 1);
    gen_instr(OP_LW, 3, 16, 2);
    gen_instr(OP_SW, 0, 16, 2);
    gen_lw_abort(2);
    gen_instr(OP_R, 2, 0, 1);

    // randomized instruction mix with occasional illegal opcodes and timeouts
    for (int unsigned n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = junk();
        while (op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW}) op = junk();
      end else begin
        op = legal[$urandom_range(0, 7)];
      end
      case ($urandom_range(0, 9))
        0:       wf = TMO;
        1:       wf = TMO - 1;
        default: wf = $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 9))
        0:       wm = TMO;
        1:       wm = $urandom_range(4, TMO - 1);
        default: wm = $urandom_range(0, 3);
      endcase
      gen_instr(op, wf, wm, $urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) gen_lw_abort($urandom_range(0, 5));
    end
    gen_instr(OP_J, 0, 0, 1);

    @(posedge clock);
    idx        = 0;
    prev_rst_n = 1'b1;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clock);
      reset_n        = it.rst_n;
      bus.mem_pronta = it.mp;
      bus.opcode     = it.op;
      bus.funct      = junk();
      #1;
      obs = sample();
      n_tests++;
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL ctl[%0d] estado=%0d observed=%h expected=%h (expected estado=%0d)",
               idx, obs.estado, obs, it.exp, it.exp.estado);
      end
      if (!prev_rst_n) begin
        n_tests++;
        if (!(obs.estado === 4'd0 && obs.erro === 1'b0 && obs.mem_le === 1'b1 &&
              obs.reg_escreve === 1'b0 && obs.mem_escreve === 1'b0)) begin
          n_fail++;
          $error("FAIL reset[%0d] estado=%0d erro=%b mem_le=%b reg_escreve=%b mem_escreve=%b",
                 idx, obs.estado, obs.erro, obs.mem_le, obs.reg_escreve, obs.mem_escreve);
        end
      end
      if (it.exp.estado == 4'd15) begin
        n_tests++;
        if (!(obs.estado === 4'd15 && obs.erro === 1'b1 && obs.pc_escreve === 1'b0 &&
              obs.ir_escreve === 1'b0 && obs.reg_escreve === 1'b0 && obs.mem_escreve === 1'b0 &&
              obs.mem_le === 1'b0 && obs.pc_escreve_cond === 1'b0)) begin
          n_fail++;
          $error("FAIL erro[%0d] estado=%0d erro=%b", idx, obs.estado, obs.erro);
        end
      end
      prev_rst_n = it.rst_n;
      idx++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
